// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order requests to a variable-latency
// instruction memory and buffers returned words in a prefetch FIFO feeding IF/ID.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        pc_write,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   fifo_pc    [DEPTH];
   logic [31:0]   fifo_instr [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;

   logic          pop;
   logic          issue;
   logic          rsp_ok;
   logic          push;
   logic [CW:0]   credit_used;
   logic [31:0]   target;

   assign target = redirect_pc & 32'hFFFF_FFFC;

   // A slot being popped this cycle is already free for a new request, which keeps
   // a 1-cycle memory streaming one instruction per cycle with only two entries.
   assign pop         = pc_write && instr_valid;
   assign credit_used = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
   assign imem_req    = rst_n && !redirect && (credit_used < (CW+1)'(DEPTH));
   assign imem_addr   = fetch_pc;
   assign issue       = imem_req && imem_gnt;

   // Responses with nothing outstanding are a protocol error and change nothing.
   assign rsp_ok = imem_rvalid && (outstanding != '0);
   assign push   = rsp_ok && !redirect && (discard == '0);

   assign instr_valid = (count != '0);
   assign instr_out   = instr_valid ? fifo_instr[rd_ptr] : 32'h0000_0000;
   assign pc_out      = instr_valid ? fifo_pc[rd_ptr]    : 32'h0000_0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CW'(issue) - CW'(rsp_ok);
         if (redirect) begin
            // Everything still in flight belongs to the wrong path.
            fetch_pc <= target;
            resp_pc  <= target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            discard  <= outstanding - CW'(rsp_ok);
         end else begin
            if (issue) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_ok && (discard != '0)) begin
               discard <= discard - CW'(1);
            end
            if (push) begin
               wr_ptr  <= wr_ptr + PW'(1);
               resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= resp_pc;
         fifo_instr[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed cycle table, random memory
// stream with in-order responses, and an asynchronous reset with requests in flight.
module tb_instr_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        pc_write;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        pw;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   int   checks = 0;
   int   errors = 0;
   vec_t vq[$];
   rsp_t mem_q[$];

   instr_fetch_unit #(
      .RESET_PC(RESET_PC),
      .DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .pc_write   (pc_write),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .instr_valid(instr_valid),
      .instr_out  (instr_out),
      .pc_out     (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns word == address, so expected instr always equals expected pc.
   function automatic vec_t mk(input logic [31:0] g, input logic [31:0] rv, input logic [31:0] rd,
                               input logic [31:0] pw, input logic [31:0] rdr, input logic [31:0] rpc,
                               input logic [31:0] req, input logic [31:0] addr,
                               input logic [31:0] vld, input logic [31:0] pc);
      vec_t v;
      v.gnt       = g[0];
      v.rvalid    = rv[0];
      v.rdata     = rd;
      v.pw        = pw[0];
      v.redir     = rdr[0];
      v.rpc       = rpc;
      v.exp_req   = req[0];
      v.exp_addr  = addr;
      v.exp_valid = vld[0];
      v.exp_pc    = pc;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      imem_gnt    = v.gnt;
      imem_rvalid = v.rvalid;
      imem_rdata  = v.rdata;
      pc_write    = v.pw;
      redirect    = v.redir;
      redirect_pc = v.rpc;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] next_addr;
      int          cyc;
      int          last_due;
      int          delivered;
      int          lat;
      rsp_t        r;

      rst_n       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      pc_write    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;

      // Stream, 5-cycle stall, redirect during stall with same-cycle rvalid,
      // redirect with two in flight, stray rvalid with nothing outstanding.
      vq.push_back(mk(1,0,0,             1,0,0,       1,'h100, 0,0));
      vq.push_back(mk(1,1,'h100,         1,0,0,       1,'h104, 0,0));
      vq.push_back(mk(1,1,'h104,         1,0,0,       1,'h108, 1,'h100));
      vq.push_back(mk(1,1,'h108,         1,0,0,       1,'h10c, 1,'h104));
      vq.push_back(mk(1,1,'h10c,         0,0,0,       0,'h110, 1,'h108));
      for (int k = 0; k < 4; k++) vq.push_back(mk(1,0,0, 0,0,0, 0,'h110, 1,'h108));
      vq.push_back(mk(1,0,0,             1,0,0,       1,'h110, 1,'h108));
      vq.push_back(mk(1,1,'h110,         1,0,0,       1,'h114, 1,'h10c));
      vq.push_back(mk(0,1,'h114,         1,0,0,       1,'h118, 1,'h110));
      vq.push_back(mk(0,0,0,             1,0,0,       1,'h118, 1,'h114));
      vq.push_back(mk(0,0,0,             1,0,0,       1,'h118, 0,0));
      vq.push_back(mk(1,0,0,             1,0,0,       1,'h118, 0,0));
      vq.push_back(mk(1,1,'h118,         1,0,0,       1,'h11c, 0,0));
      vq.push_back(mk(0,1,'h11c,         0,1,'h43,    0,'h120, 1,'h118));
      vq.push_back(mk(0,0,0,             0,0,0,       1,'h40,  0,0));
      vq.push_back(mk(1,0,0,             0,0,0,       1,'h40,  0,0));
      vq.push_back(mk(0,1,'h40,          0,0,0,       1,'h44,  0,0));
      vq.push_back(mk(0,0,0,             0,0,0,       1,'h44,  1,'h40));
      vq.push_back(mk(0,0,0,             1,0,0,       1,'h44,  1,'h40));
      vq.push_back(mk(1,0,0,             1,0,0,       1,'h44,  0,0));
      vq.push_back(mk(1,0,0,             1,0,0,       1,'h48,  0,0));
      vq.push_back(mk(1,0,0,             1,1,'h2003,  0,'h4c,  0,0));
      vq.push_back(mk(1,0,0,             1,0,0,       0,'h2000,0,0));
      vq.push_back(mk(1,1,'h44,          1,0,0,       0,'h2000,0,0));
      vq.push_back(mk(1,1,'h48,          1,0,0,       1,'h2000,0,0));
      vq.push_back(mk(1,0,0,             1,0,0,       1,'h2004,0,0));
      vq.push_back(mk(0,0,0,             1,0,0,       0,'h2008,0,0));
      vq.push_back(mk(0,1,'h2000,        1,0,0,       0,'h2008,0,0));
      vq.push_back(mk(0,1,'h2004,        1,0,0,       1,'h2008,1,'h2000));
      vq.push_back(mk(0,0,0,             1,0,0,       1,'h2008,1,'h2004));
      vq.push_back(mk(0,1,'hdead_beef,   1,0,0,       1,'h2008,0,0));
      vq.push_back(mk(0,0,0,             1,0,0,       1,'h2008,0,0));

      @(negedge clk);
      #1;
      checkOutput("reset_req",   32'(imem_req),    32'd0);
      checkOutput("reset_addr",  imem_addr,        RESET_PC);
      checkOutput("reset_valid", 32'(instr_valid), 32'd0);
      checkOutput("reset_instr", instr_out,        32'd0);
      checkOutput("reset_pc",    pc_out,           32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         applyStimulus(vq[i]);
         #1;
         checkOutput($sformatf("vec%0d_req", i),   32'(imem_req),    32'(vq[i].exp_req));
         checkOutput($sformatf("vec%0d_addr", i),  imem_addr,        vq[i].exp_addr);
         checkOutput($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vq[i].exp_valid));
         checkOutput($sformatf("vec%0d_instr", i), instr_out,        vq[i].exp_pc);
         checkOutput($sformatf("vec%0d_pc", i),    pc_out,           vq[i].exp_pc);
      end

      // Random grant/latency stream; responses stay in request order.
      exp_pc    = 32'h2008;
      next_addr = 32'h2008;
      cyc       = 0;
      last_due  = 0;
      delivered = 0;
      redirect  = 1'b0;
      while (delivered < 1000 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr;
            void'(mem_q.pop_front());
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
         end
         imem_gnt = 1'($urandom_range(0, 1));
         pc_write = ($urandom_range(0, 3) != 0);
         #1;
         if (instr_valid && pc_write) begin
            checkOutput("rnd_pc",    pc_out,    exp_pc);
            checkOutput("rnd_instr", instr_out, exp_pc);
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         if (imem_req && imem_gnt) begin
            checkOutput("rnd_addr", imem_addr, next_addr);
            lat    = int'($urandom_range(1, 6));
            r.addr = next_addr;
            r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = r.due;
            mem_q.push_back(r);
            next_addr = next_addr + 32'd4;
            checkOutput("rnd_outstanding_le_depth", 32'(mem_q.size() <= DEPTH), 32'd1);
         end
      end
      checks++;
      if (delivered < 1000) begin
         errors++;
         $display("[TB] FAIL rnd_timeout: delivered %0d, expected 1000", delivered);
      end

      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         imem_gnt = 1'b0;
         pc_write = 1'b1;
         if (mem_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr;
            void'(mem_q.pop_front());
         end else begin
            imem_rvalid = 1'b0;
         end
         #1;
         if (instr_valid) begin
            checkOutput("drain_pc", pc_out, exp_pc);
            exp_pc = exp_pc + 32'd4;
         end
      end

      // Two requests in flight, then asynchronous reset mid-cycle.
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b1;
      pc_write    = 1'b0;
      #1;
      checkOutput("pre_rst_req0",  32'(imem_req), 32'd1);
      checkOutput("pre_rst_addr0", imem_addr,     next_addr);
      @(negedge clk);
      #1;
      checkOutput("pre_rst_req1",  32'(imem_req), 32'd1);
      checkOutput("pre_rst_addr1", imem_addr,     next_addr + 32'd4);
      @(negedge clk);
      imem_gnt = 1'b0;
      #1;
      checkOutput("pre_rst_credit_out", 32'(imem_req), 32'd0);
      checkOutput("pre_rst_addr2",      imem_addr,     next_addr + 32'd8);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_req",   32'(imem_req),    32'd0);
      checkOutput("mid_rst_addr",  imem_addr,        RESET_PC);
      checkOutput("mid_rst_valid", 32'(instr_valid), 32'd0);
      checkOutput("mid_rst_instr", instr_out,        32'd0);
      checkOutput("mid_rst_pc",    pc_out,           32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      @(negedge clk);
      imem_rvalid = 1'b1;
      imem_rdata  = next_addr;
      pc_write    = 1'b1;
      #1;
      checkOutput("post_rst_req",  32'(imem_req),    32'd1);
      checkOutput("post_rst_addr", imem_addr,        RESET_PC);
      @(negedge clk);
      imem_rdata = next_addr + 32'd4;
      imem_gnt   = 1'b1;
      #1;
      checkOutput("late_rsp_ignored0", 32'(instr_valid), 32'd0);
      checkOutput("post_rst_addr1",    imem_addr,        RESET_PC);
      @(negedge clk);
      imem_gnt   = 1'b0;
      imem_rdata = RESET_PC;
      #1;
      checkOutput("late_rsp_ignored1", 32'(instr_valid), 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0;
      #1;
      checkOutput("restart_valid", 32'(instr_valid), 32'd1);
      checkOutput("restart_pc",    pc_out,           RESET_PC);
      checkOutput("restart_instr", instr_out,        RESET_PC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
